// File: rtl/mimc_hash_sequencer.sv
// Miyaguchi-Preneel MiMC hash sequencer driving one shared cipher core: h_next = E_h(m) + h + m mod PRIME.
// Optional watchdog on the core handshake is compiled in with `define MIMC_SEQ_TIMEOUT_EN.
module mimc_hash_sequencer #(
  parameter int unsigned       N_BITS         = 254,
  parameter logic [N_BITS-1:0] PRIME          = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int unsigned       TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] iv,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [N_BITS-1:0] msg_data,
  input  logic              msg_last,
  output logic              hash_valid,
  input  logic              hash_ready,
  output logic [N_BITS-1:0] hash_out,
  output logic              busy,
  output logic              core_en,
  output logic [N_BITS-1:0] core_in,
  output logic [N_BITS-1:0] core_key,
  input  logic [N_BITS-1:0] core_out,
  input  logic              core_done,
  output logic              error
);

  localparam int unsigned          SUM_W   = N_BITS + 2;
  localparam logic [SUM_W-1:0]     PRIME_W = {2'b00, PRIME};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_ACC,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic              msg_ready_q;
  logic              hash_valid_q;
  logic              core_en_q;
  logic              busy_q;
  logic              last_q;
  logic [N_BITS-1:0] h_q;
  logic [N_BITS-1:0] m_q;
  logic [N_BITS-1:0] core_out_q;
  logic [N_BITS-1:0] hash_out_q;

  logic              accept;
  logic [SUM_W-1:0]  sum_raw;
  logic [SUM_W-1:0]  sum_one;
  logic [SUM_W-1:0]  sum_two;
  logic [N_BITS-1:0] acc_d;
  logic [1:0]        unused_sum_hi;

  assign accept = msg_valid & msg_ready_q;

  // Operands are each < PRIME, so the sum is below 3*PRIME and two conditional subtractions suffice.
  always_comb begin
    sum_raw = {2'b00, core_out_q} + {2'b00, h_q} + {2'b00, m_q};
    sum_one = (sum_raw >= PRIME_W) ? sum_raw - PRIME_W : sum_raw;
    sum_two = (sum_one >= PRIME_W) ? sum_one - PRIME_W : sum_one;
    acc_d   = sum_two[N_BITS-1:0];
  end

  assign unused_sum_hi = sum_two[SUM_W-1:N_BITS];

`ifdef MIMC_SEQ_TIMEOUT_EN
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             error_q;

  assign error = error_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign error              = 1'b0;
`endif

  // NOTE: every register here is updated with non-blocking assignments so all branches see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      msg_ready_q  <= 1'b0;
      hash_valid_q <= 1'b0;
      core_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      last_q       <= 1'b0;
      h_q          <= '0;
      m_q          <= '0;
      core_out_q   <= '0;
      hash_out_q   <= '0;
`ifdef MIMC_SEQ_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      core_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            h_q         <= iv;
            m_q         <= msg_data;
            last_q      <= msg_last;
            msg_ready_q <= 1'b0;
            core_en_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_START;
`ifdef MIMC_SEQ_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
          end else begin
            msg_ready_q <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_BUSY;
`ifdef MIMC_SEQ_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        S_BUSY: begin
          if (core_done) begin
            core_out_q <= core_out;
            state_q    <= S_ACC;
          end
`ifdef MIMC_SEQ_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            msg_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
        S_ACC: begin
          h_q <= acc_d;
          if (last_q) begin
            hash_out_q   <= acc_d;
            hash_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            msg_ready_q <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (accept) begin
            m_q         <= msg_data;
            last_q      <= msg_last;
            msg_ready_q <= 1'b0;
            core_en_q   <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_DONE: begin
          if (hash_ready) begin
            hash_valid_q <= 1'b0;
            msg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          msg_ready_q  <= 1'b0;
          hash_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign msg_ready  = msg_ready_q;
  assign hash_valid = hash_valid_q;
  assign hash_out   = hash_out_q;
  assign busy       = busy_q;
  assign core_en    = core_en_q;
  assign core_in    = m_q;
  assign core_key   = h_q;

endmodule

// File: tb/tb_mimc_hash_sequencer.sv
// Self-checking bench for mimc_hash_sequencer: directed corner cases plus randomized messages against
// a plain modular-arithmetic model of the Miyaguchi-Preneel chain over a stub cipher core.
module tb_mimc_hash_sequencer;

  localparam int          N     = 254;
  localparam logic [N-1:0] P    = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam int          M_ZERO  = 0;
  localparam int          M_CONST = 1;
  localparam int          M_KEY   = 2;
  localparam int          M_FUNC  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] iv = '0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [N-1:0] msg_data = '0;
  logic         msg_last = 1'b0;
  logic         hash_valid;
  logic         hash_ready = 1'b0;
  logic [N-1:0] hash_out;
  logic         busy;
  logic         core_en;
  logic [N-1:0] core_in;
  logic [N-1:0] core_key;
  logic [N-1:0] core_out = '0;
  logic         core_done = 1'b0;
  logic         error;

  int checks = 0;
  int errors = 0;

  // stub core configuration
  int           stub_mode = M_ZERO;
  int           stub_lat = 5;
  bit           stub_rand_lat = 1'b0;
  logic [N-1:0] stub_const = '0;
  int           stub_cnt = 0;

  // observations gathered by tick()
  int           en_count = 0;
  int           en_run = 0;
  int           en_run_max = 0;
  int           both_high = 0;
  int           hv_seen = 0;
  int           err_seen = 0;
  logic [N-1:0] key_log[$];
  logic [N-1:0] elems[8];

  mimc_hash_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .iv(iv), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_last(msg_last), .hash_valid(hash_valid), .hash_ready(hash_ready),
    .hash_out(hash_out), .busy(busy), .core_en(core_en), .core_in(core_in), .core_key(core_key),
    .core_out(core_out), .core_done(core_done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] core_fn(input int mode, input logic [N-1:0] cval,
                                            input logic [N-1:0] key, input logic [N-1:0] pt);
    logic [N+7:0] t;
    case (mode)
      M_ZERO:  return '0;
      M_CONST: return cval;
      M_KEY:   return key;
      default: begin
        t = {8'd0, key} * 3 + {8'd0, pt} * 5 + 7;
        return N'(t % {8'd0, P});
      end
    endcase
  endfunction

  // One Miyaguchi-Preneel step: E_h(m) + h + m mod P.
  function automatic logic [N-1:0] mp_step(input int mode, input logic [N-1:0] cval,
                                            input logic [N-1:0] h, input logic [N-1:0] m);
    logic [N+7:0] s;
    s = {8'd0, core_fn(mode, cval, h, m)} + {8'd0, h} + {8'd0, m};
    return N'(s % {8'd0, P});
  endfunction

  function automatic logic [N-1:0] rand_fe();
    logic [255:0] r;
    if ($urandom_range(3, 0) == 0) return P - 1;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return N'(r % {2'b00, P});
  endfunction

  // Stub cipher: result and done L cycles after the core_en cycle (L=0 never finishes).
  always @(posedge clk) begin : stub_core
    int l;
    l = stub_rand_lat ? int'($urandom_range(6, 1)) : stub_lat;
    core_done <= 1'b0;
    if (core_en) begin
      core_out <= core_fn(stub_mode, stub_const, core_key, core_in);
      stub_cnt <= (l == 0) ? 0 : l - 1;
      if (l == 1) core_done <= 1'b1;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) core_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (core_en) begin
      en_count++;
      en_run++;
      if (en_run > en_run_max) en_run_max = en_run;
      key_log.push_back(core_key);
    end else begin
      en_run = 0;
    end
    if (msg_ready && hash_valid) both_high++;
    if (hash_valid) hv_seen++;
    if (error) err_seen++;
  endtask

  task automatic clear_obs();
    en_count = 0;
    en_run_max = 0;
    hv_seen = 0;
    key_log.delete();
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_msg_ready"}, N'(msg_ready), N'(0));
    check({pfx, "_hash_valid"}, N'(hash_valid), N'(0));
    check({pfx, "_hash_out"}, hash_out, N'(0));
    check({pfx, "_core_en"}, N'(core_en), N'(0));
    check({pfx, "_core_in"}, core_in, N'(0));
    check({pfx, "_core_key"}, core_key, N'(0));
    check({pfx, "_busy"}, N'(busy), N'(0));
    check({pfx, "_error"}, N'(error), N'(0));
  endtask

  // Present one element; returns at the negedge of the START cycle.
  task automatic send_elem(input logic [N-1:0] iv_v, input logic [N-1:0] d, input logic last);
    int n;
    iv = iv_v;
    msg_data = d;
    msg_last = last;
    msg_valid = 1'b1;
    n = 0;
    while (!msg_ready && n < 300) begin
      tick();
      n++;
    end
    check("accept_ready", N'(msg_ready), N'(1));
    tick();
    msg_valid = 1'b0;
    msg_last = 1'b0;
    msg_data = '0;
  endtask

  task automatic wait_hash(output int lat);
    lat = 1;
    while (!hash_valid && lat < 300) begin
      tick();
      lat++;
    end
    check("hash_valid_seen", N'(hash_valid), N'(1));
  endtask

  task automatic recv_hash(input int hold);
    logic [N-1:0] h0;
    int bad;
    h0 = hash_out;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!hash_valid || msg_ready || hash_out !== h0) bad++;
    end
    if (hold > 0) check("hold_stable", N'(bad), N'(0));
    hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    check("release_hash_valid", N'(hash_valid), N'(0));
    check("release_msg_ready", N'(msg_ready), N'(1));
    check("release_busy", N'(busy), N'(0));
  endtask

  // Send elems[0..len-1] as one message; junk iv on later elements must be ignored.
  task automatic run_msg(input logic [N-1:0] iv_v, input int len, input int gap_max,
                         output logic [N-1:0] dig, output int lat);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      send_elem((i == 0) ? iv_v : rand_fe(), elems[i], (i == len - 1));
    end
    wait_hash(lat);
    dig = hash_out;
  endtask

  initial begin
    logic [N-1:0] dig;
    logic [N-1:0] h_exp;
    logic [N-1:0] exp_keys[8];
    int           lat;
    int           n;
    int           bad;
    int           len;

    #2 rst = 1'b1;
    #1 check_outputs_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_msg_ready", N'(msg_ready), N'(1));
    check("idle_busy", N'(busy), N'(0));

    // single element, zero core: digest = m, fixed latency
    clear_obs();
    stub_mode = M_ZERO;
    stub_lat = 5;
    elems[0] = N'(5);
    run_msg(N'(0), 1, 0, dig, lat);
    check("t1_digest", dig, N'(5));
    check("t1_latency", N'(lat), N'(8));
    check("t1_core_en_count", N'(en_count), N'(1));
    check("t1_core_en_width", N'(en_run_max), N'(1));
    recv_hash(0);

    // one modular subtraction, with digest held for 10 cycles
    elems[0] = P - 1;
    run_msg(N'(2), 1, 0, dig, lat);
    check("t2_digest", dig, N'(1));
    recv_hash(10);

    // two modular subtractions: 3*P-3 -> P-3
    stub_mode = M_CONST;
    stub_const = P - 1;
    elems[0] = P - 1;
    run_msg(P - 1, 1, 0, dig, lat);
    check("t3_digest", dig, P - 3);
    recv_hash(1);

    // core echoes the key: chain 1, 4, 11 with keys 0, 1, 4
    clear_obs();
    stub_mode = M_KEY;
    stub_lat = 3;
    elems[0] = N'(1);
    elems[1] = N'(2);
    elems[2] = N'(3);
    run_msg(N'(0), 3, 2, dig, lat);
    check("t4_digest", dig, N'(11));
    check("t4_key_count", N'(key_log.size()), N'(3));
    if (key_log.size() == 3) begin
      check("t4_key0", key_log[0], N'(0));
      check("t4_key1", key_log[1], N'(1));
      check("t4_key2", key_log[2], N'(4));
    end
    recv_hash(2);

    // reset while the core is busy; its late done must be ignored
    stub_mode = M_ZERO;
    stub_lat = 20;
    send_elem(N'(7), N'(9), 1'b1);
    repeat (3) tick();
    check("t5_busy_before_reset", N'(busy), N'(1));
    #2 rst = 1'b1;
    #1 check_outputs_zero("t5_async_reset");
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (hash_valid || busy) bad++;
    end
    check("t5_late_done_ignored", N'(bad), N'(0));
    check("t5_idle_ready", N'(msg_ready), N'(1));
    check("t5_hash_out_cleared", hash_out, N'(0));

`ifdef MIMC_SEQ_TIMEOUT_EN
    // core never finishes: sticky error after 16 BUSY cycles, no digest
    clear_obs();
    stub_lat = 0;
    send_elem(N'(3), N'(1), 1'b1);
    n = 1;
    while (!error && n < 100) begin
      tick();
      n++;
    end
    check("tmo_error_cycle", N'(n), N'(18));
    check("tmo_busy", N'(busy), N'(0));
    check("tmo_msg_ready", N'(msg_ready), N'(1));
    repeat (3) tick();
    check("tmo_error_sticky", N'(error), N'(1));
    check("tmo_no_hash", N'(hv_seen), N'(0));
    stub_lat = 2;
    send_elem(N'(4), N'(6), 1'b1);
    check("tmo_error_cleared", N'(error), N'(0));
    wait_hash(lat);
    check("tmo_recovery_digest", hash_out, N'(10));
    recv_hash(0);
`endif

    // randomized messages against the modular model
    stub_mode = M_FUNC;
    stub_rand_lat = 1'b1;
    for (int k = 0; k < 12; k++) begin
      clear_obs();
      len = $urandom_range(4, 1);
      h_exp = rand_fe();
      iv = h_exp;
      for (int i = 0; i < len; i++) elems[i] = rand_fe();
      for (int i = 0; i < len; i++) begin
        exp_keys[i] = h_exp;
        h_exp = mp_step(M_FUNC, '0, h_exp, elems[i]);
      end
      run_msg(iv, len, 2, dig, lat);
      check($sformatf("rnd%0d_digest", k), dig, h_exp);
      check($sformatf("rnd%0d_key_count", k), N'(key_log.size()), N'(len));
      for (int i = 0; i < len && i < key_log.size(); i++)
        check($sformatf("rnd%0d_key%0d", k, i), key_log[i], exp_keys[i]);
      check($sformatf("rnd%0d_core_en_width", k), N'(en_run_max), N'(1));
      recv_hash($urandom_range(3, 0));
    end

    check("never_ready_and_valid", N'(both_high), N'(0));
`ifndef MIMC_SEQ_TIMEOUT_EN
    check("error_always_low", N'(err_seen), N'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mimc_hash_sequencer.md
Name: mimc_hash_sequencer

Overview:
- Drives one shared MiMC cipher core (exponent 7, 91 rounds, BN254 scalar field) to compute a Miyaguchi–Preneel MiMC hash over a stream of field elements.
- Per message element: h_next = E_h(m) + h + m mod PRIME, where E_h(m) is the cipher with key h and plaintext m.
- Sits between a valid/ready message stream and the cipher core.
- Owns the core's start, in, key and done handshake, plus the modular feed-forward addition.

Parameters:
- N_BITS, 254, field element width.
- PRIME, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field modulus; must be < 2^N_BITS.
- TIMEOUT_CYCLES, 4096, watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- iv  in  N_BITS  initial chaining value; sampled when the first element of a message is accepted.
- msg_valid  in  1  message element valid.
- msg_ready  out  1  sequencer can accept an element.
- msg_data  in  N_BITS  message element; must be < PRIME.
- msg_last  in  1  marks the final element of the message.
- hash_valid  out  1  digest available.
- hash_ready  in  1  consumer accepts the digest.
- hash_out  out  N_BITS  digest.
- busy  out  1  high whenever state != IDLE.
- core_en  out  1  one-cycle start pulse to the cipher.
- core_in  out  N_BITS  plaintext to the cipher (registered m).
- core_key  out  N_BITS  key to the cipher (registered h).
- core_out  in  N_BITS  cipher result.
- core_done  in  1  cipher result valid; sampled on the first cycle it is high after core_en.
- error  out  1  watchdog flag. Tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (async, rst=1): state IDLE. msg_ready=0, hash_valid=0, hash_out=0, core_en=0, core_in=0, core_key=0, busy=0, error=0. Internal h and m registers cleared.
- Reset mid-operation aborts immediately. A later core_done from the aborted run is ignored; the FSM only samples core_done in BUSY.
- States and transitions:
  - IDLE: msg_ready=1. On msg_valid & msg_ready: h<=iv, m<=msg_data, last<=msg_last, go to START.
  - START: core_en=1 for exactly one cycle, core_key=h, core_in=m. Go to BUSY.
  - BUSY: hold core_in and core_key stable. When core_done=1: capture core_out, go to ACC. A core_done in the same cycle as core_en (START) is ignored.
  - ACC: sum = core_out + h + m, computed at N_BITS+2 bits. Subtract PRIME while sum >= PRIME, at most twice (sum <= 3*PRIME-3). Result goes to h in one cycle. If last: hash_out<=result, go to DONE. Else go to WAIT.
  - WAIT: msg_ready=1. On accept: m<=msg_data, last<=msg_last, go to START. iv is ignored here.
  - DONE: hash_valid=1, hash_out stable. On hash_ready: hash_valid<=0, go to IDLE.
- msg_ready is 0 in START, BUSY, ACC and DONE. No back-pressure bubble beyond these states.
- Per-element latency: accept -> START (1) -> BUSY (core latency L, L>=1) -> ACC (1). The next element is accepted in the cycle after ACC, at the earliest.
- Single-element message (msg_last=1 on the first element): digest = E_iv(m) + iv + m mod PRIME.
- hash_valid and msg_ready are never both high.
- msg_data >= PRIME is a caller error. The result is then undefined but the FSM must not hang.

Optional Feature:
- Macro: MIMC_SEQ_TIMEOUT_EN.
- With it: a cycle counter resets on entry to BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES without core_done: set sticky error=1, drop the message, go to IDLE. No hash_valid is produced.
  - error clears only on rst or on the next accepted first element.
- Without it: no counter, error is constant 0, BUSY waits indefinitely.

Test Plan:
- Stub core returns 0 after 5 cycles. iv=0, single element m=5, last=1 -> hash_out=5. core_en high exactly 1 cycle. hash_valid rises 8 cycles after accept.
- Same stub. iv=2, m=PRIME-1 -> hash_out=1, exercising one modular subtraction.
- Stub returns PRIME-1. iv=PRIME-1, m=PRIME-1 -> sum=3*PRIME-3 -> hash_out=PRIME-3, exercising two subtractions.
- Stub returns core_key. 3-element message m=1,2,3, iv=0 -> h=1, then 4, then 11. hash_out=11; core_key observed 0, 1, 4.
- hash_ready held 0 for 10 cycles -> hash_valid and hash_out stable, msg_ready=0. Then hash_ready=1 -> IDLE the next cycle. rst asserted during BUSY -> all outputs 0 the same cycle; a late core_done is ignored.
- With MIMC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, stub never asserts done -> error=1 after 16 BUSY cycles, FSM returns to IDLE, hash_valid never rises.
